// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: FSM state encodings and register map.
package irq_ctl_pkg;

   typedef enum logic [1:0] {
      IRQ_IDLE = 2'd0,
      IRQ_REQ  = 2'd1,
      IRQ_SERV = 2'd2
   } irq_state_t;

   localparam logic [1:0] IRQ_A_MASK = 2'd0;
   localparam logic [1:0] IRQ_A_PEND = 2'd1;
   localparam logic [1:0] IRQ_A_STAT = 2'd2;
   localparam logic [1:0] IRQ_A_SOFT = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set index wins; o_valid flags any bit set.
module irq_prio_enc #(
   parameter int N_SRC = 8,
   parameter int ID_W  = 3
) (
   input  logic [N_SRC-1:0] i_req,
   output logic             o_valid,
   output logic [ID_W-1:0]  o_id
);

   always_comb begin
      o_valid = |i_req;
      o_id    = '0;
      // Scan downwards so the lowest index is the last assignment to stick.
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (i_req[i]) o_id = ID_W'(i);
      end
   end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller: edge capture, mask/priority, irq/iack handshake FSM, CPU register port.
// Optional macro INTC_SYNC_EN adds a 2-flop synchroniser on every irq_src line.
module irq_ctl
   import irq_ctl_pkg::*;
#(
   parameter int               N_SRC    = 8,
   parameter int               ID_W     = 3,
   parameter logic [N_SRC-1:0] MASK_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             iack,
   output logic             irq,
   output logic [ID_W-1:0]  irq_id,
   output logic             in_svc,
   input  logic             reg_wr,
   input  logic [1:0]       reg_addr,
   input  logic [N_SRC-1:0] reg_wdata,
   output logic [N_SRC-1:0] reg_rdata
);

   localparam int ST_W = ID_W + 2;

   irq_state_t       r_state, w_nxt_state;
   logic [N_SRC-1:0] r_hist, r_pend, r_mask;
   logic [ID_W-1:0]  r_irq_id;
   logic [N_SRC-1:0] w_src, w_rise, w_w1c, w_soft, w_svc_clr, w_pend_nxt, w_active;
   logic             w_win_valid;
   logic [ID_W-1:0]  w_win_id;
   logic [ST_W-1:0]  w_stat;
   logic [N_SRC-1:0] w_stat_rd;

`ifdef INTC_SYNC_EN
   logic [N_SRC-1:0] r_sync1, r_sync2;
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= irq_src;
         r_sync2 <= r_sync1;
      end
   end
   assign w_src = r_sync2;
`else
   assign w_src = irq_src;
`endif

   assign w_rise    = w_src & ~r_hist;
   assign w_w1c     = (reg_wr && reg_addr == IRQ_A_PEND) ? reg_wdata : '0;
   assign w_soft    = (reg_wr && reg_addr == IRQ_A_SOFT) ? reg_wdata : '0;
   assign w_svc_clr = (r_state == IRQ_REQ && iack) ? (N_SRC'(1) << r_irq_id) : '0;
   // New edges and soft triggers override any clear landing in the same cycle.
   assign w_pend_nxt = (r_pend & ~w_w1c & ~w_svc_clr) | w_rise | w_soft;
   assign w_active   = r_pend & r_mask;

   irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio (
      .i_req   (w_active),
      .o_valid (w_win_valid),
      .o_id    (w_win_id)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hist   <= '0;
         r_pend   <= '0;
         r_mask   <= MASK_RST;
         r_irq_id <= '0;
      end else begin
         r_hist <= w_src;
         r_pend <= w_pend_nxt;
         if (reg_wr && reg_addr == IRQ_A_MASK) r_mask <= reg_wdata;
         if (r_state == IRQ_IDLE && w_nxt_state == IRQ_REQ) r_irq_id <= w_win_id;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) r_state <= IRQ_IDLE;
      else      r_state <= w_nxt_state;
   end

   // A request is only launched once iack is seen low, so a stale iack cannot ack it.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IRQ_IDLE: if (w_win_valid && !iack) w_nxt_state = IRQ_REQ;
         IRQ_REQ:  if (iack)                 w_nxt_state = IRQ_SERV;
         IRQ_SERV: if (!iack)                w_nxt_state = IRQ_IDLE;
         default:                            w_nxt_state = IRQ_IDLE;
      endcase
   end

   always_comb begin
      irq    = (r_state == IRQ_REQ);
      in_svc = (r_state == IRQ_SERV);
      irq_id = r_irq_id;
   end

   assign w_stat = {in_svc, irq, r_irq_id};

   generate
      if (N_SRC > ST_W) begin : g_stat_pad
         assign w_stat_rd = {{(N_SRC - ST_W){1'b0}}, w_stat};
      end else if (N_SRC == ST_W) begin : g_stat_eq
         assign w_stat_rd = w_stat;
      end else begin : g_stat_trunc
         assign w_stat_rd = w_stat[N_SRC-1:0];
      end
   endgenerate

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         IRQ_A_MASK: reg_rdata = r_mask;
         IRQ_A_PEND: reg_rdata = r_pend;
         IRQ_A_STAT: reg_rdata = w_stat_rd;
         default:    reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: capture, priority, handshake, masking, soft trigger, reset.
module tb_irq_ctl;

   import irq_ctl_pkg::*;

`ifdef INTC_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_src;
   logic       iack;
   logic       irq;
   logic [2:0] irq_id;
   logic       in_svc;
   logic       reg_wr;
   logic [1:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   int n_cmp = 0;
   int n_err = 0;

   irq_ctl #(.N_SRC(8), .ID_W(3), .MASK_RST(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .irq_src   (irq_src),
      .iack      (iack),
      .irq       (irq),
      .irq_id    (irq_id),
      .in_svc    (in_svc),
      .reg_wr    (reg_wr),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      reg_wr    = 1'b1;
      reg_addr  = a;
      reg_wdata = d;
      tick(1);
      reg_wr    = 1'b0;
      reg_wdata = 8'h00;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
      reg_addr = a;
      #1;
      check(tag, 32'(reg_rdata), 32'(exp));
   endtask

   task automatic chk_out(input string tag, input logic e_irq, input logic [2:0] e_id,
                          input logic e_svc);
      check({tag, ".irq"},    32'(irq),    32'(e_irq));
      check({tag, ".irq_id"}, 32'(irq_id), 32'(e_id));
      check({tag, ".in_svc"}, 32'(in_svc), 32'(e_svc));
   endtask

   initial begin
      rst = 1'b0; irq_src = 8'h00; iack = 1'b0;
      reg_wr = 1'b0; reg_addr = 2'd0; reg_wdata = 8'h00;
      tick(3);
      chk_out("reset", 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      tick(1);
      rd_chk("reset.pend", IRQ_A_PEND, 8'h00);
      rd_chk("reset.mask", IRQ_A_MASK, 8'h00);
      rd_chk("reset.stat", IRQ_A_STAT, 8'h00);

      // Basic capture and handshake on src2
      wr(IRQ_A_MASK, 8'h05);
      rd_chk("t1.mask", IRQ_A_MASK, 8'h05);
      irq_src = 8'h04;
      tick(1 + SL);
      rd_chk("t1.pend", IRQ_A_PEND, 8'h04);
      check("t1.irq_early", 32'(irq), 32'd0);
      tick(1);
      chk_out("t1.req", 1'b1, 3'd2, 1'b0);
      rd_chk("t1.stat_req", IRQ_A_STAT, 8'h0A);
      iack = 1'b1;
      tick(1);
      chk_out("t1.serv", 1'b0, 3'd2, 1'b1);
      rd_chk("t1.pend_clr", IRQ_A_PEND, 8'h00);
      iack = 1'b0;
      tick(1);
      chk_out("t1.ret", 1'b0, 3'd2, 1'b0);
      irq_src = 8'h00;
      tick(2);

      // Simultaneous edges on src5 and src1: lowest index first
      wr(IRQ_A_MASK, 8'hFF);
      irq_src = 8'h22;
      tick(1 + SL);
      rd_chk("t2.pend", IRQ_A_PEND, 8'h22);
      tick(1);
      chk_out("t2.req1", 1'b1, 3'd1, 1'b0);
      iack = 1'b1;
      tick(1);
      chk_out("t2.serv1", 1'b0, 3'd1, 1'b1);
      rd_chk("t2.pend_after1", IRQ_A_PEND, 8'h20);
      iack = 1'b0;
      tick(1);
      chk_out("t2.ret1", 1'b0, 3'd1, 1'b0);
      tick(1);
      chk_out("t2.req5", 1'b1, 3'd5, 1'b0);
      iack = 1'b1;
      tick(1);
      iack = 1'b0;
      tick(1);
      irq_src = 8'h00;
      tick(2);

      // All masked: pending accumulates, no request until unmasked
      wr(IRQ_A_MASK, 8'h00);
      irq_src = 8'h08;
      tick(1 + SL);
      rd_chk("t3.pend", IRQ_A_PEND, 8'h08);
      tick(3);
      check("t3.masked_irq", 32'(irq), 32'd0);
      wr(IRQ_A_MASK, 8'h08);
      check("t3.unmask_irq_early", 32'(irq), 32'd0);
      tick(1);
      chk_out("t3.req", 1'b1, 3'd3, 1'b0);
      iack = 1'b1;
      tick(1);
      iack = 1'b0;
      tick(1);
      irq_src = 8'h00;
      tick(2);

      // Mask and W1C during REQ do not retract irq; soft trigger during SERV
      wr(IRQ_A_MASK, 8'h01);
      irq_src = 8'h01;
      tick(1 + SL);
      tick(1);
      chk_out("t4.req0", 1'b1, 3'd0, 1'b0);
      wr(IRQ_A_MASK, 8'h00);
      wr(IRQ_A_PEND, 8'h01);
      rd_chk("t4.pend_w1c", IRQ_A_PEND, 8'h00);
      rd_chk("t4.stat", IRQ_A_STAT, 8'h08);
      tick(2);
      check("t4.irq_held", 32'(irq), 32'd1);
      iack = 1'b1;
      tick(1);
      chk_out("t4.serv0", 1'b0, 3'd0, 1'b1);
      wr(IRQ_A_SOFT, 8'h80);
      rd_chk("t4.soft_pend", IRQ_A_PEND, 8'h80);
      rd_chk("t4.soft_rd", IRQ_A_SOFT, 8'h00);
      wr(IRQ_A_MASK, 8'hFF);
      tick(2);
      chk_out("t4.no_nest", 1'b0, 3'd0, 1'b1);
      iack = 1'b0;
      tick(1);
      chk_out("t4.ret", 1'b0, 3'd0, 1'b0);
      tick(1);
      chk_out("t4.req7", 1'b1, 3'd7, 1'b0);
      irq_src = 8'h00;

      // Reset asserted mid-request
      rst = 1'b0;
      tick(1);
      chk_out("t5.rst", 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      tick(1);
      rd_chk("t5.mask", IRQ_A_MASK, 8'h00);
      rd_chk("t5.pend", IRQ_A_PEND, 8'h00);

      // iack high while idle blocks a new request until it drops
      iack = 1'b1;
      wr(IRQ_A_MASK, 8'hFF);
      wr(IRQ_A_SOFT, 8'h02);
      rd_chk("t6.pend", IRQ_A_PEND, 8'h02);
      tick(3);
      chk_out("t6.stale_iack", 1'b0, 3'd0, 1'b0);
      iack = 1'b0;
      tick(1);
      chk_out("t6.req1", 1'b1, 3'd1, 1'b0);

      // Re-edge of the serviced source is re-pended and requested after return
      iack = 1'b1;
      tick(1);
      rd_chk("t7.pend_clr", IRQ_A_PEND, 8'h00);
      irq_src = 8'h02;
      tick(1 + SL);
      rd_chk("t7.repend", IRQ_A_PEND, 8'h02);
      chk_out("t7.serv", 1'b0, 3'd1, 1'b1);
      iack = 1'b0;
      tick(1);
      chk_out("t7.ret", 1'b0, 3'd1, 1'b0);
      tick(1);
      chk_out("t7.rereq", 1'b1, 3'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
